// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default sizes.
package serial_adder_ctrl_pkg;

  // IDLE waits for start, RUN shifts one bit per clock, DONE is the one-cycle result slot.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, time-shared by the serial adder across all bit positions.
module Full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one Full_adder,
// the carry lives in a flip-flop and the sum is assembled in a shift register.
//
// Handshake: start is a request that is accepted on a rising edge only when the
// FSM is in IDLE or DONE; a, b and cin are captured on that edge and may change
// afterwards. busy is high for exactly WIDTH cycles while bits are processed.
// done is a registered one-cycle pulse, and sum/cout are valid in that cycle and
// hold until the next done. start while busy is ignored.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;
  logic             r_cout;
  logic             r_done;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_s_final;

  // The one shared full-adder cell sees the current LSBs and the running carry.
  Full_adder u_fa (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Cin  (r_carry),
    .Sum  (w_fa_sum),
    .Cout (w_fa_cout)
  );

  // A new add is accepted only when no add is in flight.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_count == CNT_W'(WIDTH - 1));

  // Sum shift register after this edge: new bit enters at the MSB.
  generate
    if (WIDTH == 1) begin : g_one_bit
      assign w_s_final = w_fa_sum;
    end else begin : g_multi_bit
      assign w_s_final = {w_fa_sum, r_s_sh[WIDTH-1:1]};
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; DONE can go straight back to RUN for back-to-back adds.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial shifting, carry FF and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= b;
        r_carry <= cin;
        r_count <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sh  <= r_a_sh >> 1;
        r_b_sh  <= r_b_sh >> 1;
        r_s_sh  <= w_s_final;
        r_carry <= w_fa_cout;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_sum  <= w_s_final;
          r_cout <= w_fa_cout;
        end
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 instance checked by a scoreboard fed from
// an a+b+cin reference model, plus a WIDTH=1 instance for the truth table.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int W   = 8;
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic         start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;
  logic [1:0]   dbg_state;

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .dbg_state(dbg_state)
  );

  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;
  logic [1:0] dbg_state1;

  serial_adder_ctrl #(.WIDTH(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];
  int         exp_cyc_q[$];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  bit         abort_flag = 1'b0;
  logic [W:0] held = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // ---------------- monitor ----------------
  int  run_len = 0;
  bit  prev_done = 1'b0;
  always @(negedge clk) begin
    logic [W:0] e;
    int ec;
    if (!rst) begin
      if (busy) begin
        run_len++;
        if (!abort_flag) chk("hold_during_run", {23'd0, cout, sum}, {23'd0, held});
      end else if (run_len != 0) begin
        if (!abort_flag) chk("busy_len", run_len, W);
        abort_flag = 1'b0;
        run_len = 0;
      end
      if (done) begin
        done_cnt++;
        chk("done_not_consecutive", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%0h required=no_done", {cout, sum});
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("sum", sum, e[W-1:0]);
          chk("cout", cout, e[W]);
          chk("latency_cycle", cyc, ec);
          held = e;
        end
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is sampled on the following rising edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    logic [W:0] e;
    a = ia; b = ib; cin = ic; start = 1'b1;
    e = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done within %0d cycles", TMO);
    end
  endtask

  task automatic run_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input int gap);
    issue(ia, ib, ic);
    wait_done();
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [1:0] e1;
    logic [2:0] v;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_state", dbg_state, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed operands
    run_add(8'h5A, 8'h3C, 1'b0, 1);
    run_add(8'hFF, 8'h01, 1'b0, 1);
    run_add(8'hFF, 8'h00, 1'b1, 1);
    run_add(8'h00, 8'h00, 1'b0, 1);

    // start held during RUN with new operands: exactly one done with the first result
    base = done_cnt;
    issue(8'h12, 8'h34, 1'b0);
    a = 8'hAA; b = 8'hBB; cin = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (2 * W) @(negedge clk);
    chk("one_done_for_held_start", done_cnt - base, 32'd1);

    // back-to-back: second add accepted in the DONE cycle
    run_add(8'h40, 8'h40, 1'b0, 0);
    run_add(8'h01, 8'h01, 1'b0, 2);

    // abort during RUN bit 4 of 8'h0F + 8'h01
    base = done_cnt;
    issue(8'h0F, 8'h01, 1'b0);
    repeat (4) @(negedge clk);
    abort_flag = 1'b1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    held = '0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", sum, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2 * W) @(negedge clk);
    chk("abort_no_done", done_cnt - base, 32'd0);
    run_add(8'h0F, 8'h01, 1'b0, 1);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      int n;
      v = 3'(i);
      a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1'b1;
      e1 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < TMO) begin
        @(negedge clk);
        n++;
      end
      chk("w1_done_seen", {31'd0, done1}, 32'd1);
      chk("w1_sum", {31'd0, sum1}, {31'd0, e1[0]});
      chk("w1_cout", {31'd0, cout1}, {31'd0, e1[1]});
      @(negedge clk);
    end

    // random adds, gap 0 gives back-to-back issue
    for (int i = 0; i < 1000; i++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    repeat (2 * W) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
